// File: rtl/flash_sample_sequencer_if.sv
// Avalon-MM read-master bundle between the sample sequencer and the audio flash.
// master: sequencer side, slave: flash controller side.
interface flash_sample_sequencer_if #(
    parameter int ADDR_W = 23
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic [3:0]        flash_byteenable;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read, flash_address, flash_byteenable,
        input  flash_waitrequest, flash_readdata, flash_readdatavalid
    );

    modport slave (
        input  flash_read, flash_address, flash_byteenable,
        output flash_waitrequest, flash_readdata, flash_readdatavalid
    );
endinterface

// File: rtl/flash_sample_sequencer.sv
// flash_sample_sequencer: one Avalon read per 32-bit flash word, split into two
// 16-bit samples on successive sample ticks; addr_step asks the updater for the
// next word once both halves are out.
// Optional feature: define SEQ_TIMEOUT_EN to bound the wait for readdatavalid.
module flash_sample_sequencer #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic                      enable,
    input  logic                      dir_fwd,
    input  logic [ADDR_W-1:0]         addr,
    flash_sample_sequencer_if.master  flash,
    output logic [15:0]               sample_out,
    output logic                      sample_valid,
    output logic                      addr_step,
    output logic                      underrun,
    output logic                      timeout_err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ       = 3'd1;
    localparam logic [2:0] WAIT_DATA = 3'd2;
    localparam logic [2:0] EMIT1     = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;
    localparam logic [2:0] EMIT2     = 3'd5;

    logic [2:0]        state;
    logic              dir_q;
    logic [31:0]       word_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;

    assign flash.flash_read       = rd_q;
    assign flash.flash_address    = addr_q;
    assign flash.flash_byteenable = 4'b1111;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in WAIT_DATA; held at zero elsewhere so entry starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_cnt <= '0;
        else if (state != WAIT_DATA)
            to_cnt <= '0;
        else if (!to_hit)
            to_cnt <= to_cnt + 1'b1;
    end

    // Sticky flag: readdatavalid never came within the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout_err <= 1'b0;
        else if (state == WAIT_DATA && !flash.flash_readdatavalid && to_hit)
            timeout_err <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif

    // A tick arriving before the word is ready means the flash round trip is too slow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun <= 1'b0;
        else if (sample_tick && (state == REQ || state == WAIT_DATA || state == EMIT1))
            underrun <= 1'b1;
    end

    // Main sequencer; outputs are registered so each pulse lands in the state it names.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dir_q        <= 1'b0;
            word_q       <= '0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            addr_step    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            addr_step    <= 1'b0;
            case (state)
                IDLE: begin
                    // Stray readdatavalid (e.g. from a read cut by reset) is ignored here.
                    if (sample_tick && enable) begin
                        addr_q <= addr;
                        dir_q  <= dir_fwd;
                        rd_q   <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // Request must stay up until accepted; it cannot be withdrawn.
                    if (!flash.flash_waitrequest) begin
                        rd_q  <= 1'b0;
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash.flash_readdatavalid) begin
                        word_q       <= flash.flash_readdata;
                        sample_out   <= dir_q ? flash.flash_readdata[15:0]
                                              : flash.flash_readdata[31:16];
                        sample_valid <= 1'b1;
                        state        <= EMIT1;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        // Emit silence and move on so playback does not stall.
                        sample_out   <= '0;
                        sample_valid <= 1'b1;
                        addr_step    <= 1'b1;
                        state        <= IDLE;
                    end
`endif
                end
                EMIT1: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // Tick while paused is swallowed; the word stays half-consumed.
                    if (sample_tick && enable) begin
                        sample_out   <= dir_q ? word_q[31:16] : word_q[15:0];
                        sample_valid <= 1'b1;
                        addr_step    <= 1'b1;
                        state        <= EMIT2;
                    end
                end
                EMIT2: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer: stimulus pushes expected samples to
// a queue, a negedge monitor pops one per sample_valid pulse.
module tb_flash_sample_sequencer;

    localparam int ADDR_W = 23;
    localparam int TO     = 16;

    typedef struct packed {
        logic [15:0] d;
        logic        step;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_tick = 1'b0;
    logic              enable = 1'b0;
    logic              dir_fwd = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       sample_out;
    logic              sample_valid;
    logic              addr_step;
    logic              underrun;
    logic              timeout_err;

    flash_sample_sequencer_if #(.ADDR_W(ADDR_W)) flash_bus ();

    flash_sample_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .enable       (enable),
        .dir_fwd      (dir_fwd),
        .addr         (addr),
        .flash        (flash_bus.master),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .addr_step    (addr_step),
        .underrun     (underrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    // Scoreboard monitor: every sample_valid pulse must match the next expected sample.
    always @(negedge clk) begin
        if (!reset) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample_valid", 32'(sample_out), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sample_out", 32'(sample_out), 32'(e.d));
                    check("addr_step", 32'(addr_step), 32'(e.step));
                end
            end else if (addr_step) begin
                check("addr_step_without_valid", 32'(addr_step), 32'd0);
            end
            if (flash_bus.flash_read && !flash_bus.flash_waitrequest)
                n_acc++;
        end
    end

    // Wait for the read request, check its address, accept after ws wait cycles.
    task automatic accept(input logic [ADDR_W-1:0] a, input int ws);
        for (int i = 0; i < 20 && !flash_bus.flash_read; i++) cyc();
        check("flash_read_seen", 32'(flash_bus.flash_read), 32'd1);
        check("flash_address", 32'(flash_bus.flash_address), 32'(a));
        repeat (ws) cyc();
        flash_bus.flash_waitrequest = 1'b0;
        cyc();
        flash_bus.flash_waitrequest = 1'b1;
        check("flash_read_dropped", 32'(flash_bus.flash_read), 32'd0);
    endtask

    // Full word: tick, Avalon read, first half, second tick (optionally paused first).
    task automatic do_word(input logic [ADDR_W-1:0] a, input logic d, input logic [31:0] w,
                           input bit pause, input bit extra_tick);
        logic [15:0] first, second;
        first  = d ? w[15:0]  : w[31:16];
        second = d ? w[31:16] : w[15:0];
        exp_q.push_back('{d: first,  step: 1'b0});
        exp_q.push_back('{d: second, step: 1'b1});
        addr = a; dir_fwd = d; enable = 1'b1;
        tick();
        accept(a, 2);
        for (int i = 0; i < 2; i++) begin
            if (i == 0 && extra_tick) sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
        end
        flash_bus.flash_readdatavalid = 1'b1;
        flash_bus.flash_readdata      = w;
        cyc();
        flash_bus.flash_readdatavalid = 1'b0;
        flash_bus.flash_readdata      = 32'h0;
        check("first_half_timing", 32'({sample_valid, sample_out}), 32'({1'b1, first}));
        // A dir_fwd change now must not affect the word in flight.
        dir_fwd = ~d;
        repeat (2) cyc();
        if (pause) begin
            enable = 1'b0;
            tick();
            check("paused_no_pulse", 32'({sample_valid, addr_step}), 32'd0);
            repeat (2) cyc();
            enable = 1'b1;
        end
        tick();
        check("second_half_timing", 32'({sample_valid, addr_step, sample_out}),
              32'({1'b1, 1'b1, second}));
        repeat (3) cyc();
    endtask

    initial begin
        flash_bus.flash_waitrequest   = 1'b1;
        flash_bus.flash_readdata      = 32'h0;
        flash_bus.flash_readdatavalid = 1'b0;
        repeat (3) cyc();
        check("reset_outputs", 32'({flash_bus.flash_read, sample_valid, addr_step, underrun,
                                    timeout_err, sample_out}), 32'd0);
        check("reset_address", 32'(flash_bus.flash_address), 32'd0);
        check("byteenable", 32'(flash_bus.flash_byteenable), 32'hF);
        reset = 1'b0;
        cyc();

        do_word(23'h00010, 1'b1, 32'hBEEF_1234, 1'b0, 1'b0);   // forward
        do_word(23'h00010, 1'b0, 32'hBEEF_1234, 1'b0, 1'b0);   // backward
        check("no_underrun_yet", 32'(underrun), 32'd0);
        do_word(23'h00011, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0);   // pause in HOLD
        do_word(23'h00012, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1);   // underrun
        check("underrun_set", 32'(underrun), 32'd1);
        check("reads_accepted", 32'(n_acc), 32'd4);

        // Reset while waiting for data; the late readdatavalid must be ignored.
        addr = 23'h7FF; dir_fwd = 1'b1; enable = 1'b1;
        tick();
        accept(23'h7FF, 0);
        cyc();
        reset = 1'b1;
        #1;
        check("reset_mid_outputs", 32'({flash_bus.flash_read, sample_valid, addr_step, underrun,
                                        sample_out}), 32'd0);
        check("reset_mid_address", 32'(flash_bus.flash_address), 32'd0);
        cyc();
        reset = 1'b0;
        enable = 1'b0;
        cyc();
        flash_bus.flash_readdatavalid = 1'b1;
        flash_bus.flash_readdata      = 32'h1111_2222;
        cyc();
        flash_bus.flash_readdatavalid = 1'b0;
        check("late_rdv_no_valid", 32'({sample_valid, flash_bus.flash_read}), 32'd0);
        repeat (3) cyc();

        // Boundary address and sign-extreme sample values; FSM must be back in IDLE.
        do_word(23'h7FFFFF, 1'b0, 32'h8000_7FFF, 1'b0, 1'b0);
        check("reads_accepted_final", 32'(n_acc), 32'd6);

`ifdef SEQ_TIMEOUT_EN
        exp_q.push_back('{d: 16'h0000, step: 1'b1});
        addr = 23'h5; enable = 1'b1;
        tick();
        accept(23'h5, 0);
        repeat (TO + 4) cyc();
        check("timeout_err", 32'(timeout_err), 32'd1);
`else
        check("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        repeat (2) cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flash_sample_sequencer.md
# flash_sample_sequencer

Sequences 32-bit word reads from the audio flash over an Avalon-MM read master and splits each word into two 16-bit samples at the sample-rate strobe. Sits between the address-updater FSM, which supplies the current word address, direction and play/pause, and the audio output path. Issues exactly one flash read per word. Pulses `addr_step` once both halves are consumed so the updater advances.

## Interface
- `ADDR_W`, 23, flash word-address width
- `TIMEOUT_CYCLES`, 255, cycles allowed for `flash_readdatavalid` after the read is accepted; used only with `SEQ_TIMEOUT_EN`
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `sample_tick`  in  1  one-cycle sample-rate strobe, synchronous to `clk`
- `enable`  in  1  1 = playing, 0 = paused
- `dir_fwd`  in  1  1 = forward playback, 0 = backward playback
- `addr`  in  ADDR_W  word address from the updater
- `flash_read`  out  1  Avalon read request
- `flash_address`  out  ADDR_W  Avalon address
- `flash_byteenable`  out  4  constant 4'b1111
- `flash_waitrequest`  in  1  Avalon waitrequest
- `flash_readdata`  in  32  Avalon read data
- `flash_readdatavalid`  in  1  Avalon read data valid
- `sample_out`  out  16  current sample; holds its value between updates
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates
- `addr_step`  out  1  one-cycle pulse requesting the next word address
- `underrun`  out  1  sticky; cleared only by reset
- `timeout_err`  out  1  sticky; tied 0 without `SEQ_TIMEOUT_EN`

## Operation
- States:
  - IDLE
  - REQ
  - WAIT_DATA
  - EMIT1
  - HOLD
  - EMIT2
- IDLE:
  - `flash_read`=0.
  - On `sample_tick` && `enable`: latch `addr` into `flash_address`, latch `dir_fwd` into `dir_q`, go to REQ.
  - `flash_readdatavalid` is ignored in IDLE.
- REQ:
  - `flash_read`=1 and `flash_address` are held stable.
  - In the cycle `flash_waitrequest`=0, the request is accepted; go to WAIT_DATA.
- WAIT_DATA:
  - `flash_read`=0.
  - On `flash_readdatavalid`, capture `flash_readdata` into `word_q` and go to EMIT1.
- EMIT1:
  - `sample_out` = `dir_q` ? `word_q[15:0]` : `word_q[31:16]`; `sample_valid`=1.
  - Go to HOLD.
- HOLD:
  - Wait for `sample_tick`.
  - On a tick with `enable`=1, go to EMIT2.
  - On a tick with `enable`=0, stay in HOLD with no pulses (pause mid-word).
- EMIT2:
  - `sample_out` = the other half; `sample_valid`=1 and `addr_step`=1 in the same cycle.
  - Go to IDLE.
- Direction is latched per word; a `dir_fwd` change takes effect at the next read.
- `enable` falling during REQ or WAIT_DATA: the Avalon transaction completes and EMIT1 still occurs; pause then takes effect in HOLD.
- A `sample_tick` seen in REQ, WAIT_DATA or EMIT1 sets `underrun`=1. The tick is otherwise dropped; no extra read, no state change.
- `sample_out` is passed through unchanged (signed 16-bit); no arithmetic is applied.

## Timing
- Reset values (asynchronous; reset may assert in any state):
  - State IDLE.
  - `flash_read`=0, `flash_address`=0, `sample_out`=0, `sample_valid`=0, `addr_step`=0, `underrun`=0, `timeout_err`=0, `word_q`=0.
- `flash_read` asserts the cycle after the accepting tick and stays high through the first cycle with `flash_waitrequest`=0.
- `sample_valid` for the first half: one cycle after the `flash_readdatavalid` cycle.
- `sample_valid` for the second half, together with `addr_step`: one cycle after the accepting tick in HOLD.
- The updater must present the new `addr` before the next `sample_tick`; the gap of ≥2 cycles is guaranteed by tick spacing.
- Reset mid-transaction: `flash_read` drops immediately; a `flash_readdatavalid` arriving after reset produces no `sample_valid`.
- Requirement on the system: the flash round trip must fit within one tick period; otherwise `underrun` flags it.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DATA, cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` without `flash_readdatavalid`:
    - `sample_out`=0, `sample_valid`=1, `addr_step`=1 in one cycle.
    - `timeout_err` is set (sticky).
    - Go to IDLE.
  - The counter does not run in REQ; Avalon forbids withdrawing an unaccepted request.
- `SEQ_TIMEOUT_EN` undefined: WAIT_DATA waits indefinitely; no counter logic is generated; `timeout_err`=0.

## Test plan
- Forward word:
  - Stimulus: `addr`=0x00010, `dir_fwd`=1, `enable`=1, tick. `flash_waitrequest` high 2 cycles; `flash_readdatavalid` with 0xBEEF1234 3 cycles later.
  - Response: `flash_address`=0x00010; `sample_out`=0x1234 with a 1-cycle `sample_valid`. Next tick gives 0xBEEF, with `addr_step` in the same cycle.
- Backward word:
  - Stimulus: same as the forward case with `dir_fwd`=0.
  - Response: 0xBEEF first, then 0x1234 with `addr_step`.
- Pause in HOLD:
  - Stimulus: `enable`=0 at the second tick, then `enable`=1 at the third tick.
  - Response: the second tick gives no `sample_valid` or `addr_step`. The third tick gives the second half.
- Underrun:
  - Stimulus: extra tick while in WAIT_DATA.
  - Response: `underrun`=1, `flash_read` pulses exactly once, and the sequence completes normally.
- Reset mid-read:
  - Stimulus: assert `reset` in WAIT_DATA, release it, then drive a late `flash_readdatavalid`.
  - Response: all outputs 0; no `sample_valid`; state IDLE.
- Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - Stimulus: no `flash_readdatavalid` after acceptance.
  - Response: 16 cycles later `sample_out`=0x0000, `sample_valid`=1, `addr_step`=1, `timeout_err`=1.
